// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle between the nibble-serial add/subtract controller and its
// environment: operation request/response plus the shared 4-bit adder.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_sum;
    logic         adder_cout;

    // Environment side: issues operations and owns the shared ripple adder.
    modport master (
        output start, sub, op_a, op_b, adder_sum, adder_cout,
        input  busy, done, result, carry_out, overflow,
        input  adder_a, adder_b, adder_cin
    );

    // Controller side.
    modport slave (
        input  start, sub, op_a, op_b, adder_sum, adder_cout,
        output busy, done, result, carry_out, overflow,
        output adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller. Walks the operands one 4-bit slice
// per cycle through an external combinational 4-bit adder, LSB slice first,
// and assembles the W-bit result with final carry and signed overflow.
//
// state | meaning
// IDLE  | waiting for start, adder inputs held at 0
// RUN   | one slice per edge through the shared adder, busy high
// DONE  | one-cycle done pulse, result valid; start here chains a new op
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  op_a_q;
    logic [W-1:0]  op_b_q;
    logic          sub_q;
    logic          carry_q;
    logic [W-1:0]  result_q;
    logic          carry_out_q;
    logic          overflow_q;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    adder_a_q;
    logic [3:0]    adder_b_q;

    logic [IW-1:0] idx_next;
    logic          last_slice;
    logic [3:0]    next_a;
    logic [3:0]    next_b;

    // Select the operand slices the adder will see after the current edge.
    always_comb begin
        idx_next   = idx + 1'b1;
        last_slice = (int'(idx) == NIBBLES - 1);
        next_a     = '0;
        next_b     = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (int'(idx_next) == i) begin
                next_a = op_a_q[4*i +: 4];
                next_b = op_b_q[4*i +: 4] ^ {4{sub_q}};
            end
        end
    end

    // Sequencer: accepts operations, steps slices, registers all outputs.
    // The adder inputs are registered one step ahead so they are stable for
    // the whole cycle in which the external adder evaluates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_a_q    <= bus.op_a;
                        op_b_q    <= bus.op_b;
                        sub_q     <= bus.sub;
                        idx       <= '0;
                        carry_q   <= bus.sub;
                        adder_a_q <= bus.op_a[3:0];
                        adder_b_q <= bus.op_b[3:0] ^ {4{bus.sub}};
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result_q[4*idx +: 4] <= bus.adder_sum;
                    if (last_slice) begin
                        carry_out_q <= bus.adder_cout;
                        overflow_q  <= (adder_a_q[3] == adder_b_q[3]) &&
                                       (bus.adder_sum[3] != adder_a_q[3]);
                        // The carry register doubles as adder_cin, which must
                        // read 0 outside RUN, so the last carry is kept only
                        // in carry_out.
                        carry_q     <= 1'b0;
                        adder_a_q   <= '0;
                        adder_b_q   <= '0;
                        idx         <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        carry_q   <= bus.adder_cout;
                        adder_a_q <= next_a;
                        adder_b_q <= next_b;
                        idx       <= idx_next;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.adder_a   = adder_a_q;
    assign bus.adder_b   = adder_b_q;
    assign bus.adder_cin = carry_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with NIBBLES=4. The shared
// adder is a 5-bit a+b+cin model; expected results are hand-computed.
module tb_nibble_serial_add_ctrl;
    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   n_cyc;
    int   n_busy;
    logic saw_done;

    nibble_serial_add_ctrl_if #(.NIBBLES(4)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared ripple adder model.
    assign {bus.adder_cout, bus.adder_sum} =
        {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {4'b0, bus.adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen (bounded); counts edges and busy cycles.
    task automatic wait_done(output int cyc, output int nb);
        cyc = 0;
        nb  = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) nb++;
            step();
            cyc++;
        end
    endtask

    // One full operation; returns in the DONE cycle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] exp_r,
                          input logic exp_c, input logic exp_v);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        step();
        bus.start = 1'b0;
        check({tag, "_adder_a0"}, 32'(bus.adder_a), 32'(a[3:0]));
        check({tag, "_adder_b0"}, 32'(bus.adder_b), 32'(b[3:0] ^ {4{s}}));
        check({tag, "_adder_cin0"}, 32'(bus.adder_cin), 32'(s));
        wait_done(n_cyc, n_busy);
        check({tag, "_latency"}, 32'(n_cyc), 32'd4);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'd4);
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
        check({tag, "_carry_out"}, 32'(bus.carry_out), 32'(exp_c));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_v));
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_carry_out", 32'(bus.carry_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("idle_adder", {23'd0, bus.adder_a, bus.adder_b, bus.adder_cin}, 32'd0);

        run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("done_adder_zero", {23'd0, bus.adder_a, bus.adder_b, bus.adder_cin}, 32'd0);
        step();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("result_hold", 32'(bus.result), 32'h0100);
        step();

        run_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        step();
        run_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        step();
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        step();
        run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        step();

        // start held high with changing operands during RUN
        bus.start = 1'b1;
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h2222;
        bus.sub   = 1'b0;
        step();
        bus.op_a  = 16'hAAAA;
        bus.op_b  = 16'h5555;
        bus.sub   = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        wait_done(n_cyc, n_busy);
        check("held_start_latency", 32'(n_cyc), 32'd2);
        check("held_start_result", 32'(bus.result), 32'h3333);
        check("held_start_carry", 32'(bus.carry_out), 32'd0);
        step();

        // reset on the second RUN edge aborts the operation
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h1111;
        bus.sub   = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", 32'(bus.result), 32'h0);
        check("abort_done", 32'(bus.done), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            step();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        run_op("after_abort", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
        step();

        // back-to-back: new start accepted in the DONE cycle
        run_op("b2b_first", 16'h4444, 16'h1111, 1'b0, 16'h5555, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h1111;
        bus.sub   = 1'b0;
        step();
        bus.start = 1'b0;
        check("b2b_no_gap_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        check("b2b_result_hold", 32'(bus.result), 32'h5555);
        wait_done(n_cyc, n_busy);
        check("b2b_latency", 32'(n_cyc), 32'd4);
        check("b2b_result", 32'(bus.result), 32'h2345);
        check("b2b_carry", 32'(bus.carry_out), 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
